alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, which is the data word width (the codebase `WORD).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have port z, output, WIDTH bits, the registered result.
REQ-005 The module SHALL have port ALUop, input, 5 bits, the operation select.
REQ-006 The module SHALL have port X, input, WIDTH bits, the first operand.
REQ-007 The module SHALL have port Y, input, WIDTH bits, the second operand.
REQ-008 The port order SHALL be z, ALUop, X, Y, clk, rst_n, so that positional instantiation (z, ALUop, X, Y) remains valid.

Function
REQ-009 z SHALL equal f(ALUop, X, Y) as sampled at the previous rising clk edge: exactly 1-cycle latency, no handshake, a new operation accepted every cycle.
REQ-010 The opcodes SHALL be: 00000 ADD X+Y; 00001 SUB X-Y; 00010 AND; 00011 OR; 00100 XOR; 00101 NOT X; 00110 NEG -X (two's complement).
REQ-011 Further opcodes SHALL be: 00111 SHL X<<Y[3:0]; 01000 SHR logical X>>Y[3:0]; 01001 SAR arithmetic X>>>Y[3:0]; 01010 SLT signed (X<Y ? 1 : 0); 01011 SLTU unsigned; 01100 PASSX; 01101 PASSY.
REQ-012 Additional opcodes SHALL be: 01110 MUL, the low WIDTH bits of X*Y; 01111 EQ (X==Y ? 1 : 0).
REQ-013 ADD, SUB, NEG and MUL SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-014 The shift count SHALL use only Y[3:0]; upper Y bits SHALL be ignored; a count of 0 SHALL return X unchanged.
REQ-015 SAR SHALL replicate X[WIDTH-1]; SHR and SHL SHALL fill with zeros.
REQ-016 SLT, SLTU and EQ SHALL zero-extend their 1-bit result to WIDTH.
REQ-017 Any unassigned opcode (10000-11111) SHALL produce z = 0 on the next edge.
REQ-018 The result SHALL be purely a function of the current inputs; there SHALL be no internal state other than the z register.
REQ-019 z SHALL never be X/Z after reset for any defined input.

Reset
REQ-020 While rst_n = 0, z SHALL be 0 immediately (asynchronously), independent of clk.
REQ-021 On the first rising clk edge after rst_n deasserts, z SHALL load f(ALUop, X, Y).
REQ-022 Reset asserted mid-stream SHALL discard the pending result; no stale value SHALL appear after release.

Structure
REQ-023 A shared package SHALL hold WORD width (16) and the named ALUop constants (OP_ADD..OP_EQ).
REQ-024 The shift logic (SHL/SHR/SAR) SHALL live in one sub-module, alu_shifter (combinational, X, amount[3:0], mode -> result).
REQ-025 The remaining operations SHALL be a single combinational case on ALUop feeding the z register.

Verification
REQ-026 The bench SHALL check ADD X=0x7FFF, Y=0x0001 -> z=0x8000 one cycle later; ADD 0xFFFF+0x0001 -> 0x0000.
REQ-027 The bench SHALL check SUB X=0x0003, Y=0x0005 -> 0xFFFE; NEG X=0x0001 -> 0xFFFF; NOT X=0x00FF -> 0xFF00.
REQ-028 The bench SHALL check SAR X=0x8000, Y=0x000F -> 0xFFFF; SHR with the same operands -> 0x0001; SHL X=0x0001, Y=0x0013 -> 0x0008.
REQ-029 The bench SHALL check SLT X=0xFFFF, Y=0x0001 -> 0x0001; SLTU with the same operands -> 0x0000; MUL 0x0100*0x0100 -> 0x0000.
REQ-030 The bench SHALL check opcode 11111 with X=0x1234, Y=0x5678 -> 0x0000.
REQ-031 The bench SHALL check: drive rst_n=0 between edges while z=0x1234 -> z=0 with no clk edge; on release, z SHALL hold 0 until the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared word width, opcode constants and shift mode type for the ALU
package alu_pkg;

   localparam int WORD = 16;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_NOT  = 5'b00101;
   localparam logic [4:0] OP_NEG  = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_SHR  = 5'b01000;
   localparam logic [4:0] OP_SAR  = 5'b01001;
   localparam logic [4:0] OP_SLT  = 5'b01010;
   localparam logic [4:0] OP_SLTU = 5'b01011;
   localparam logic [4:0] OP_PASSX = 5'b01100;
   localparam logic [4:0] OP_PASSY = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_EQ   = 5'b01111;

   typedef enum logic [1:0] {
      SH_LEFT  = 2'd0,
      SH_RIGHT = 2'd1,
      SH_ARITH = 2'd2
   } shift_mode_t;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode/result bundle for driving and observing the ALU
interface alu_if
   import alu_pkg::*;
#(
   parameter int WIDTH = WORD
);
   logic [4:0]       ALUop;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] z;

   modport master (output ALUop, output X, output Y, input z);
   modport slave  (input ALUop, input X, input Y, output z);
endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational barrel shifter: logical left/right and arithmetic right
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   input  logic [WIDTH-1:0] x,
   input  logic [3:0]       amount,
   input  shift_mode_t      mode,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = x;
      case (mode)
         SH_LEFT:  result = x << amount;
         SH_RIGHT: result = x >> amount;
         SH_ARITH: result = $signed(x) >>> amount;
         default:  result = x;
      endcase
   end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle ALU with one registered result stage
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   output logic [WIDTH-1:0] z,
   input  logic [4:0]       ALUop,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             clk,
   input  logic             rst_n
);

   shift_mode_t      shift_mode;
   logic [WIDTH-1:0] shift_result;
   logic [WIDTH-1:0] mul_low;
   logic [WIDTH-1:0] next_z;

   always_comb begin
      shift_mode = SH_LEFT;
      case (ALUop)
         OP_SHR:  shift_mode = SH_RIGHT;
         OP_SAR:  shift_mode = SH_ARITH;
         default: shift_mode = SH_LEFT;
      endcase
   end

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .x      (X),
      .amount (Y[3:0]),
      .mode   (shift_mode),
      .result (shift_result)
   );

   assign mul_low = X * Y;

   // Compare results occupy bit 0 only; everything above is zero.
   always_comb begin
      next_z = '0;
      case (ALUop)
         OP_ADD:   next_z = X + Y;
         OP_SUB:   next_z = X - Y;
         OP_AND:   next_z = X & Y;
         OP_OR:    next_z = X | Y;
         OP_XOR:   next_z = X ^ Y;
         OP_NOT:   next_z = ~X;
         OP_NEG:   next_z = -X;
         OP_SHL,
         OP_SHR,
         OP_SAR:   next_z = shift_result;
         OP_SLT:   next_z = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
         OP_SLTU:  next_z = {{(WIDTH-1){1'b0}}, (X < Y)};
         OP_PASSX: next_z = X;
         OP_PASSY: next_z = Y;
         OP_MUL:   next_z = mul_low;
         OP_EQ:    next_z = {{(WIDTH-1){1'b0}}, (X == Y)};
         default:  next_z = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z <= '0;
      end else begin
         z <= next_z;
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for the ALU
module tb_alu;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_if #(.WIDTH(16)) bus ();

   alu #(.WIDTH(16)) dut (
      .z     (bus.z),
      .ALUop (bus.ALUop),
      .X     (bus.X),
      .Y     (bus.Y),
      .clk   (clk),
      .rst_n (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
      @(negedge clk);
      bus.ALUop = op;
      bus.X     = x;
      bus.Y     = y;
   endtask

   task automatic run(input string tag, input logic [4:0] op, input logic [15:0] x,
                      input logic [15:0] y, input logic [15:0] expected);
      apply(op, x, y);
      @(posedge clk);
      #1;
      check(tag, bus.z, expected);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.ALUop = OP_ADD;
      bus.X     = 16'h1111;
      bus.Y     = 16'h2222;
      #1;
      check("reset_async", bus.z, 16'h0000);
      @(posedge clk);
      #1;
      check("reset_held", bus.z, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_reset", bus.z, 16'h3333);

      run("add_ovf",    OP_ADD,  16'h7FFF, 16'h0001, 16'h8000);
      run("add_wrap",   OP_ADD,  16'hFFFF, 16'h0001, 16'h0000);
      run("sub",        OP_SUB,  16'h0003, 16'h0005, 16'hFFFE);
      run("neg",        OP_NEG,  16'h0001, 16'h0000, 16'hFFFF);
      run("not",        OP_NOT,  16'h00FF, 16'h0000, 16'hFF00);
      run("and",        OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030);
      run("or",         OP_OR,   16'hF0F0, 16'h3C3C, 16'hFCFC);
      run("xor",        OP_XOR,  16'hF0F0, 16'h3C3C, 16'hCCCC);
      run("sar_neg",    OP_SAR,  16'h8000, 16'h000F, 16'hFFFF);
      run("sar_pos",    OP_SAR,  16'h4000, 16'h0001, 16'h2000);
      run("shr",        OP_SHR,  16'h8000, 16'h000F, 16'h0001);
      run("shl_mask",   OP_SHL,  16'h0001, 16'h0013, 16'h0008);
      run("shl_zero",   OP_SHL,  16'hBEEF, 16'h0010, 16'hBEEF);
      run("slt",        OP_SLT,  16'hFFFF, 16'h0001, 16'h0001);
      run("sltu",       OP_SLTU, 16'hFFFF, 16'h0001, 16'h0000);
      run("mul_wrap",   OP_MUL,  16'h0100, 16'h0100, 16'h0000);
      run("mul",        OP_MUL,  16'h0012, 16'h0003, 16'h0036);
      run("eq_true",    OP_EQ,   16'hABCD, 16'hABCD, 16'h0001);
      run("eq_false",   OP_EQ,   16'hABCD, 16'hABCE, 16'h0000);
      run("passy",      OP_PASSY, 16'h1111, 16'h5A5A, 16'h5A5A);
      run("undef_op",   5'b11111, 16'h1234, 16'h5678, 16'h0000);
      run("passx",      OP_PASSX, 16'h1234, 16'h0000, 16'h1234);

      // Async reset between edges, then release before the next edge.
      apply(OP_ADD, 16'h0002, 16'h0003);
      #1;
      check("pre_reset_hold", bus.z, 16'h1234);
      rst_n = 1'b0;
      #1;
      check("mid_reset_async", bus.z, 16'h0000);
      rst_n = 1'b1;
      #1;
      check("released_hold", bus.z, 16'h0000);
      @(posedge clk);
      #1;
      check("load_after_release", bus.z, 16'h0005);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
